sel_tab: RTL and testbench
==========================

Name: sel_tab

Overview:
- Selection (chooser) table for a tournament branch predictor: 1024 entries × 2-bit selector counters, indexed by a 10-bit branch address/hash.
- Provides a combinational read of the addressed entry to the predictor's choice logic.
- Accepts whole-entry overwrites from the update path; saturating-counter arithmetic lives in the update logic, not in this block.

Parameters:
- ADDR_W, 10, index width; table depth is 2**ADDR_W.
- DATA_W, 2, entry (selector counter) width.
- INIT_VAL, 2'b01, value loaded into every entry on reset (weak preference for predictor 0).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- up_en  input  1  write enable for the update path.
- up_data  input  DATA_W  new entry value written at addr when up_en=1.
- addr  input  ADDR_W  shared read/write index.
- rd_data  output  DATA_W  current contents of entry[addr].

Behaviour:
- One clock (clk); reset is synchronous and active-high. The port name is `reset`.
- Storage is a register array entry[0 .. 2**ADDR_W-1], each DATA_W bits.
- Reset:
  - On a rising clk edge with reset=1, every entry is loaded with INIT_VAL in that single cycle.
  - Reset has priority over up_en; no write occurs in the reset cycle.
- Write:
  - On a rising clk edge with reset=0 and up_en=1, entry[addr] <= up_data.
  - No other entry changes.
  - Write latency is one edge.
- Read:
  - rd_data = entry[addr], purely combinational with zero-cycle latency from addr.
  - rd_data follows addr changes immediately, with no clock needed.
- Read-during-write:
  - In the write cycle, rd_data shows the old value until the edge.
  - After the edge, rd_data shows up_data, provided addr is unchanged.
  - No write-through bypass.
- up_en=0: the table is unchanged and up_data is don't-care (X/Z on up_data must not corrupt state).
- Output after reset: rd_data = INIT_VAL for any addr.
- Before the first reset, contents are undefined; the bench must not check them.
- Address boundaries:
  - Index 0 and 2**ADDR_W-1 are ordinary entries.
  - There is no wrap or out-of-range case, since addr width equals the index width.
- Reset mid-operation: a reset asserted in a cycle where up_en=1 discards the write; all entries become INIT_VAL.
- Back-to-back writes to different addresses on consecutive edges all take effect.
- Back-to-back writes to the same address: the last one wins.
- No X propagation from unwritten entries once reset has been applied.

Decomposition:
- Shared package sel_tab_pkg holds:
  - ADDR_W/DATA_W defaults.
  - Selector encoding constants: SEL_STRONG_P0=2'b00, SEL_WEAK_P0=2'b01, SEL_WEAK_P1=2'b10, SEL_STRONG_P1=2'b11.
  - A sel_t typedef (logic [DATA_W-1:0]).
- Interpretation of rd_data[1] as the predictor choice belongs to the consumer.
- Single flat module; no sub-module warranted.

Test Plan:
- Reset then read: pulse reset for one edge; set addr=1, 2, 3 with up_en=0 and up_data=2'b11 → rd_data=2'b01 at each address; table unchanged.
- Directed writes: up_en=1 with (addr, up_data) = (0, 01), (1, 00), (2, 11), (3, 01) on consecutive edges; then up_en=0 and read 0..3 → 01, 00, 11, 01. During each write cycle, rd_data shows the pre-edge value; after the edge it shows the new value.
- Boundary addresses: write 2'b10 at addr=1023 and 2'b11 at addr=0 → readback 10 and 11; addr=1022 still reads 01.
- up_en=0 hold: drive up_data=2'b00 with up_en=0 at addr=2 (holding 11) for 3 edges → rd_data stays 11.
- Reset priority: reset=1 and up_en=1 at addr=5 with up_data=2'b11 in the same cycle → after the edge rd_data(addr 5)=01, and previously written entries (0..3, 1023) read 01.
- Same-address overwrite: write 00 then 11 to addr=7 on consecutive edges → rd_data=11.

Source files
------------

// File: rtl/sel_tab_pkg.sv
// Shared types and constants for the tournament-predictor selection table.
// Selector encoding runs from strong-P0 (00) to strong-P1 (11).
package sel_tab_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 2;

  typedef logic [DATA_W_DEF-1:0] sel_t;

  localparam sel_t SEL_STRONG_P0 = 2'b00;
  localparam sel_t SEL_WEAK_P0   = 2'b01;
  localparam sel_t SEL_WEAK_P1   = 2'b10;
  localparam sel_t SEL_STRONG_P1 = 2'b11;

endpackage

// File: rtl/sel_tab.sv
// Selection table: 2**ADDR_W selector counters with a combinational read port
// and a single whole-entry write port sharing one address.
module sel_tab
  import sel_tab_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = SEL_WEAK_P0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_en,
  input  logic [DATA_W-1:0] up_data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] entry_q [DEPTH];

  // Table storage: reset loads every entry and overrides any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= INIT_VAL;
      end
    end else if (up_en) begin
      entry_q[addr] <= up_data;
    end
  end

  // No bypass: a write becomes visible only after its clock edge.
  assign rd_data = entry_q[addr];

endmodule

// File: tb/tb_sel_tab.sv
// Directed bench for sel_tab: a reference array updated from the table rules,
// checked every cycle, plus hand-computed literal expectations.
module tb_sel_tab;

  logic       clk;
  logic       reset;
  logic       up_en;
  logic [1:0] up_data;
  logic [9:0] addr;
  logic [1:0] rd_data;

  int   n_checks;
  int   n_fail;
  logic chk_en;

  logic [1:0] model [1024];

  sel_tab dut (
    .clk     (clk),
    .reset   (reset),
    .up_en   (up_en),
    .up_data (up_data),
    .addr    (addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: reset fills with weak-P0, otherwise enabled writes land.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) model[i] <= 2'b01;
    end else if (up_en === 1'b1) begin
      model[addr] <= up_data;
    end
  end

  // Mid-cycle comparison against the reference table.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (rd_data !== model[addr]) begin
        n_fail++;
        $display("FAIL model_cmp addr=%0d got=%b exp=%b", addr, rd_data, model[addr]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [1:0] exp);
    #1;
    n_checks++;
    if (rd_data !== exp) begin
      n_fail++;
      $display("FAIL %s addr=%0d got=%b exp=%b", name, addr, rd_data, exp);
    end
  endtask

  logic [9:0] wa [4];
  logic [1:0] wd [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    up_en    = 1'b0;
    up_data  = 2'b00;
    addr     = 10'd0;
    wa[0] = 10'd0; wd[0] = 2'b01;
    wa[1] = 10'd1; wd[1] = 2'b00;
    wa[2] = 10'd2; wd[2] = 2'b11;
    wa[3] = 10'd3; wd[3] = 2'b01;

    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset then read with a disabled write pending.
    up_data = 2'b11;
    for (int a = 1; a <= 3; a++) begin
      addr = 10'(a);
      check_lit("rst_read", 2'b01);
      tick();
    end
    addr = 10'd1;
    check_lit("rst_no_write", 2'b01);

    // Back-to-back writes: old value before the edge, new value after.
    for (int i = 0; i < 4; i++) begin
      addr    = wa[i];
      up_data = wd[i];
      up_en   = 1'b1;
      check_lit("rdw_old", 2'b01);
      tick();
      up_en = 1'b0;
      check_lit("rdw_new", wd[i]);
    end
    for (int i = 0; i < 4; i++) begin
      addr = wa[i];
      check_lit("readback", wd[i]);
    end

    // Boundary addresses.
    addr = 10'd1023; up_data = 2'b10; up_en = 1'b1;
    tick();
    addr = 10'd0; up_data = 2'b11;
    tick();
    up_en = 1'b0;
    addr = 10'd1023;
    check_lit("bound_hi", 2'b10);
    addr = 10'd0;
    check_lit("bound_lo", 2'b11);
    addr = 10'd1022;
    check_lit("bound_neigh", 2'b01);

    // Hold with writes disabled, including an undriven data bus.
    addr = 10'd2; up_data = 2'b00; up_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_lit("hold", 2'b11);
    end
    up_data = 2'bxx;
    tick();
    check_lit("hold_x", 2'b11);

    // Reset wins over a simultaneous write.
    addr = 10'd5; up_data = 2'b11; up_en = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; up_en = 1'b0;
    check_lit("rst_prio", 2'b01);
    for (int i = 0; i < 4; i++) begin
      addr = wa[i];
      check_lit("rst_clear", 2'b01);
    end
    addr = 10'd1023;
    check_lit("rst_clear_hi", 2'b01);

    // Same-address overwrite: last write wins.
    addr = 10'd7; up_en = 1'b1; up_data = 2'b00;
    tick();
    check_lit("ovw_first", 2'b00);
    up_data = 2'b11;
    tick();
    up_en = 1'b0;
    check_lit("ovw_last", 2'b11);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
